// File: rtl/psram_rsp_pkg.sv
// Shared types and constants for the OPI DDR PSRAM responder.
// Optional byte masking during memory writes is enabled with PSRAM_RSP_DM_EN.
package psram_rsp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    LAT   = 3'd3,
    WDATA = 3'd4,
    RDATA = 3'd5,
    DROP  = 3'd6
  } state_e;

  localparam logic [7:0] DEF_CMD_RD  = 8'h00;
  localparam logic [7:0] DEF_CMD_WR  = 8'h80;
  localparam logic [7:0] DEF_CMD_RRD = 8'h40;
  localparam logic [7:0] DEF_CMD_RWR = 8'hC0;
  localparam logic [7:0] DEF_RLC     = 8'd5;
  localparam logic [7:0] DEF_WLC     = 8'd5;

  localparam logic [1:0] MR_RLC = 2'd0;
  localparam logic [1:0] MR_WLC = 2'd1;

  // Latency is counted in sck edges, two per sck cycle.
  function automatic logic [8:0] lat_edges(input logic [7:0] l);
    return {l, 1'b0};
  endfunction

endpackage

// File: rtl/psram_rsp_edge.sv
// Input registering and sck edge detection for the PSRAM responder.
// Every sck transition (either direction) is a DDR beat carrying the io/dqs sample.
module psram_rsp_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce,
  input  logic [7:0] io,
  input  logic       dqs,
  output logic       beat_valid,
  output logic [7:0] beat_data,
  output logic       beat_dm,
  output logic       ce_act
);

  logic       sck_q1_r;
  logic       sck_q2_r;
  logic       ce_q1_r;
  logic [7:0] io_q1_r;
  logic       dqs_q1_r;

  // Single sampling stage plus a delayed sck copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q1_r <= 1'b0;
      sck_q2_r <= 1'b0;
      ce_q1_r  <= 1'b1;
      io_q1_r  <= 8'h00;
      dqs_q1_r <= 1'b0;
    end else begin
      sck_q1_r <= sck;
      sck_q2_r <= sck_q1_r;
      ce_q1_r  <= ce;
      io_q1_r  <= io;
      dqs_q1_r <= dqs;
    end
  end

  assign beat_valid = sck_q1_r ^ sck_q2_r;
  assign beat_data  = io_q1_r;
  assign beat_dm    = dqs_q1_r;
  assign ce_act     = ~ce_q1_r;

endmodule

// File: rtl/psram_opi_rsp.sv
// OPI DDR PSRAM responder: decodes cmd/addr/latency/data beats and serves a byte array plus 4 mode registers.
// Define PSRAM_RSP_DM_EN to let dqs_in mask bytes during memory writes.
module psram_opi_rsp
  import psram_rsp_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter logic [7:0]  CMD_RD    = DEF_CMD_RD,
  parameter logic [7:0]  CMD_WR    = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RRD   = DEF_CMD_RRD,
  parameter logic [7:0]  CMD_RWR   = DEF_CMD_RWR,
  parameter logic [7:0]  RLC_RST   = DEF_RLC,
  parameter logic [7:0]  WLC_RST   = DEF_WLC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic       psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
`ifdef PSRAM_RSP_DM_EN
  localparam logic DM_EN = 1'b1;
`else
  localparam logic DM_EN = 1'b0;
`endif

  logic       beat_valid_s;
  logic [7:0] beat_data_s;
  logic       beat_dm_s;
  logic       ce_act_s;

  psram_rsp_edge u_edge (
    .clk        (clk_i),
    .rst        (rst_i),
    .sck        (psram_sck_i),
    .ce         (psram_ce_i),
    .io         (psram_io_in_i),
    .dqs        (psram_dqs_in_i),
    .beat_valid (beat_valid_s),
    .beat_data  (beat_data_s),
    .beat_dm    (beat_dm_s),
    .ce_act     (ce_act_s)
  );

  state_e          state_r, state_s;
  logic [1:0]      cnt_r, cnt_s;
  logic [7:0]      op_r, op_s;
  logic [31:0]     addr_r, addr_s;
  logic [8:0]      lat_r, lat_s;
  logic [3:0][7:0] mr_r, mr_s;
  logic [7:0]      io_out_r, io_out_s;
  logic            io_en_r, io_en_s;
  logic            dqs_out_r, dqs_out_s;
  logic            dqs_en_r, dqs_en_s;
  logic            busy_r;
  logic            cmd_err_r, cmd_err_s;
  logic            mem_we_s;

  logic [7:0]      mem_r [MEM_DEPTH];

  logic [AW-1:0]   idx_s;
  logic [31:0]     addr_inc_s;
  logic [7:0]      lat_len_s;
  logic [7:0]      rd_byte_s;
  logic            known_s;
  logic            rd_op_s;
  logic            dm_mask_s;
  state_e          data_st_s;

  assign idx_s      = addr_r[AW-1:0];
  assign addr_inc_s = {addr_r[31:AW], idx_s + AW'(1'b1)};
  assign known_s    = (beat_data_s == CMD_RD) || (beat_data_s == CMD_WR) ||
                      (beat_data_s == CMD_RRD) || (beat_data_s == CMD_RWR);
  assign rd_op_s    = (op_r != CMD_WR) && (op_r != CMD_RWR);
  assign data_st_s  = rd_op_s ? RDATA : WDATA;
  assign lat_len_s  = (op_r == CMD_WR)  ? mr_r[MR_WLC] :
                      (op_r == CMD_RWR) ? 8'd0 : mr_r[MR_RLC];
  assign rd_byte_s  = (op_r == CMD_RRD) ? mr_r[addr_r[1:0]] : mem_r[idx_s];
  assign dm_mask_s  = DM_EN & beat_dm_s;

  // Next-state and next-output decode, one step per detected beat.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    op_s      = op_r;
    addr_s    = addr_r;
    lat_s     = lat_r;
    mr_s      = mr_r;
    io_out_s  = io_out_r;
    io_en_s   = io_en_r;
    dqs_out_s = dqs_out_r;
    dqs_en_s  = dqs_en_r;
    cmd_err_s = 1'b0;
    mem_we_s  = 1'b0;
    if (!ce_act_s) begin
      // Deselect wins over any beat sampled in the same clock.
      state_s   = IDLE;
      io_en_s   = 1'b0;
      dqs_en_s  = 1'b0;
      dqs_out_s = 1'b0;
      io_out_s  = 8'h00;
    end else if (state_r == IDLE) begin
      state_s = CMD;
      cnt_s   = 2'd0;
    end else if (beat_valid_s) begin
      case (state_r)
        CMD: begin
          if (cnt_r == 2'd0) begin
            op_s  = beat_data_s;
            cnt_s = 2'd1;
            if (!known_s) begin
              cmd_err_s = 1'b1;
              state_s   = DROP;
            end else begin
              state_s = CMD;
            end
          end else begin
            state_s = ADDR;
            cnt_s   = 2'd0;
          end
        end
        ADDR: begin
          addr_s = {addr_r[23:0], beat_data_s};
          cnt_s  = cnt_r + 2'd1;
          lat_s  = lat_edges(lat_len_s);
          if (cnt_r != 2'd3) begin
            state_s = ADDR;
          end else if (lat_len_s != 8'd0) begin
            state_s = LAT;
          end else begin
            state_s   = data_st_s;
            io_en_s   = rd_op_s;
            dqs_en_s  = rd_op_s;
            dqs_out_s = 1'b0;
          end
        end
        LAT: begin
          if (lat_r == 9'd1) begin
            state_s   = data_st_s;
            io_en_s   = rd_op_s;
            dqs_en_s  = rd_op_s;
            dqs_out_s = 1'b0;
          end else begin
            lat_s = lat_r - 9'd1;
          end
        end
        WDATA: begin
          // A mode-register write takes only its first data beat.
          if (op_r == CMD_RWR) begin
            if (cnt_r == 2'd0) begin
              mr_s[addr_r[1:0]] = beat_data_s;
              cnt_s             = 2'd1;
            end else begin
              cnt_s = cnt_r;
            end
          end else begin
            mem_we_s = ~dm_mask_s;
            addr_s   = addr_inc_s;
          end
        end
        RDATA: begin
          io_out_s  = rd_byte_s;
          dqs_out_s = ~dqs_out_r;
          if (op_r == CMD_RRD) begin
            addr_s = addr_r;
          end else begin
            addr_s = addr_inc_s;
          end
        end
        DROP:    state_s = DROP;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, mode registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= 2'd0;
      op_r      <= 8'h00;
      addr_r    <= 32'h0000_0000;
      lat_r     <= 9'd0;
      mr_r      <= {8'h00, 8'h00, WLC_RST, RLC_RST};
      io_out_r  <= 8'h00;
      io_en_r   <= 1'b0;
      dqs_out_r <= 1'b0;
      dqs_en_r  <= 1'b0;
      busy_r    <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      addr_r    <= addr_s;
      lat_r     <= lat_s;
      mr_r      <= mr_s;
      io_out_r  <= io_out_s;
      io_en_r   <= io_en_s;
      dqs_out_r <= dqs_out_s;
      dqs_en_r  <= dqs_en_s;
      busy_r    <= (state_s != IDLE);
      cmd_err_r <= cmd_err_s;
    end
  end

  // Backing array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= beat_data_s;
    end
  end

  assign psram_io_out_o  = io_out_r;
  assign psram_io_en_o   = io_en_r;
  assign psram_dqs_out_o = dqs_out_r;
  assign psram_dqs_en_o  = dqs_en_r;
  assign busy_o          = busy_r;
  assign cmd_err_o       = cmd_err_r;

endmodule

// File: tb/tb_psram_opi_rsp.sv
// Directed plus randomized bench for psram_opi_rsp against a byte-array/mode-register reference model.
// Honours PSRAM_RSP_DM_EN when computing expected write results.
module tb_psram_opi_rsp;

  localparam int D = 4096;
  localparam logic [7:0] OP_RD  = 8'h00;
  localparam logic [7:0] OP_WR  = 8'h80;
  localparam logic [7:0] OP_RRD = 8'h40;
  localparam logic [7:0] OP_RWR = 8'hC0;
`ifdef PSRAM_RSP_DM_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic       dqs_in = 1'b0;
  logic [7:0] io_out;
  logic       io_en, dqs_out, dqs_en, busy, cmd_err;

  psram_opi_rsp dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .psram_sck_i     (sck),
    .psram_ce_i      (ce),
    .psram_io_in_i   (io_in),
    .psram_io_out_o  (io_out),
    .psram_io_en_o   (io_en),
    .psram_dqs_in_i  (dqs_in),
    .psram_dqs_out_o (dqs_out),
    .psram_dqs_en_o  (dqs_en),
    .busy_o          (busy),
    .cmd_err_o       (cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int en_cnt = 0;

  logic [7:0] mdl_mem [D];
  logic [7:0] mdl_mr [4];
  logic [7:0] wdat [16];

  always @(negedge clk) begin
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (io_en) en_cnt <= en_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [7:0] op);
    if (op == OP_WR) return int'(mdl_mr[1]);
    else if (op == OP_RWR) return 0;
    else return int'(mdl_mr[0]);
  endfunction

  // One DDR beat: data and strobe change together with the sck toggle.
  task automatic beat(input logic [7:0] d, input logic dm);
    @(negedge clk);
    io_in = d;
    dqs_in = dm;
    sck = ~sck;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [31:0] a);
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    beat(op, 1'b0);
    beat(8'h00, 1'b0);
    for (int i = 3; i >= 0; i--) beat(a[8*i +: 8], 1'b0);
  endtask

  task automatic end_cmd(input bit with_beat);
    @(negedge clk);
    ce = 1'b1;
    if (with_beat) begin
      sck = ~sck;
      io_in = 8'h5A;
    end
    @(negedge clk);
    check("busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("io_en_off", 32'(io_en), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_burst(input logic [7:0] op, input logic [31:0] a, input int n,
                          input int dm_beat, input bit cut);
    int l;
    l = lat_of(op);
    start_cmd(op, a);
    for (int k = 0; k < 2 * l; k++) beat(8'($urandom), 1'b0);
    for (int i = 0; i < n; i++) begin
      beat(wdat[i], (i == dm_beat));
      if (op == OP_RWR) begin
        if (i == 0) mdl_mr[a[1:0]] = wdat[i];
      end else if (!(DM_EN && (i == dm_beat))) begin
        mdl_mem[(a + 32'(i)) & 32'(D - 1)] = wdat[i];
      end
    end
    check("wr_no_en", 32'(io_en), 32'd0);
    end_cmd(cut);
  endtask

  task automatic rd_burst(input logic [7:0] op, input logic [31:0] a, input int n);
    int l;
    logic [7:0] exp;
    l = lat_of(op);
    start_cmd(op, a);
    check("en_after_addr", 32'(io_en), 32'(l == 0));
    for (int k = 0; k < 2 * l; k++) begin
      beat(8'($urandom), 1'b0);
      check("lat_en", 32'(io_en), 32'(k == 2 * l - 1));
    end
    check("dqs_en", 32'(dqs_en), 32'd1);
    check("dqs_init", 32'(dqs_out), 32'd0);
    for (int i = 0; i < n; i++) begin
      beat(8'($urandom), 1'b0);
      exp = (op == OP_RRD) ? mdl_mr[a[1:0]] : mdl_mem[(a + 32'(i)) & 32'(D - 1)];
      check("rd_data", 32'(io_out), 32'(exp));
      check("rd_dqs", 32'(dqs_out), 32'((i % 2) == 0));
    end
    end_cmd(1'b0);
  endtask

  initial begin
    int e0, n0, n, a;
    mdl_mr[0] = 8'd5; mdl_mr[1] = 8'd5; mdl_mr[2] = 8'd0; mdl_mr[3] = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_io_en", 32'(io_en), 32'd0);
    check("rst_dqs_en", 32'(dqs_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_dqs_out", 32'(dqs_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write then read with default latencies.
    wdat[0] = 8'hA0; wdat[1] = 8'hA1; wdat[2] = 8'hA2; wdat[3] = 8'hA3;
    wr_burst(OP_WR, 32'h10, 4, -1, 1'b0);
    rd_burst(OP_RD, 32'h10, 4);

    // Read latency 3 through MR0, then mode-register readback.
    wdat[0] = 8'h03;
    wr_burst(OP_RWR, 32'h0, 1, -1, 1'b0);
    rd_burst(OP_RD, 32'h10, 4);
    rd_burst(OP_RRD, 32'h0, 3);
    rd_burst(OP_RRD, 32'h1, 2);

    // Unknown opcode: one error pulse, never drives, stays busy until deselect.
    e0 = err_cnt; n0 = en_cnt;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    beat(8'h55, 1'b0);
    check("err_pulse", 32'(err_cnt), 32'(e0 + 1));
    for (int k = 0; k < 6; k++) beat(8'($urandom), 1'b0);
    check("err_single", 32'(err_cnt), 32'(e0 + 1));
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_no_en", 32'(en_cnt), 32'(n0));
    end_cmd(1'b0);

    // Wrap at the top of the array.
    wdat[0] = 8'($urandom); wdat[1] = 8'($urandom);
    wr_burst(OP_WR, 32'(D - 1), 2, -1, 1'b0);
    rd_burst(OP_RD, 32'h0, 1);
    rd_burst(OP_RD, 32'(D - 1), 2);

    // Burst cut after two bytes; a beat coincident with deselect is dropped.
    for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
    wr_burst(OP_WR, 32'h100, 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
    wr_burst(OP_WR, 32'h100, 2, -1, 1'b1);
    rd_burst(OP_RD, 32'h100, 4);

    // Strobe high on data beat 1.
    for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
    wr_burst(OP_WR, 32'h200, 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = wdat[i] ^ 8'hFF;
    wr_burst(OP_WR, 32'h200, 4, 1, 1'b0);
    rd_burst(OP_RD, 32'h200, 4);

    // Random latencies (including zero), addresses and lengths.
    for (int it = 0; it < 6; it++) begin
      wdat[0] = 8'($urandom_range(3, 0));
      wr_burst(OP_RWR, 32'h1, 1, -1, 1'b0);
      wdat[0] = 8'($urandom_range(3, 0));
      wr_burst(OP_RWR, 32'h0, 1, -1, 1'b0);
      a = int'($urandom_range(D - 1, 0));
      n = int'($urandom_range(8, 1));
      for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
      wr_burst(OP_WR, 32'(a), n, -1, 1'b0);
      rd_burst(OP_RD, 32'(a), n);
    end

    // Reset in the middle of a read burst.
    start_cmd(OP_RD, 32'h10);
    for (int k = 0; k < 2 * lat_of(OP_RD); k++) beat(8'h00, 1'b0);
    beat(8'h00, 1'b0);
    beat(8'h00, 1'b0);
    check("pre_rst_en", 32'(io_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_en", 32'(io_en), 32'd0);
    check("rst_mid_dqs_en", 32'(dqs_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    ce = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_mr[0] = 8'd5; mdl_mr[1] = 8'd5; mdl_mr[2] = 8'd0; mdl_mr[3] = 8'd0;
    repeat (2) @(negedge clk);
    rd_burst(OP_RRD, 32'h0, 1);
    rd_burst(OP_RRD, 32'h1, 1);
    rd_burst(OP_RD, 32'h10, 2);

    check("err_total", 32'(err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
